// File: rtl/psum_accumulator_if.sv
// Handshake bundle between the adder tree, the partial-sum accumulator and
// the downstream row-result consumer.
interface psum_accumulator_if #(
    parameter int IN_W  = 25,
    parameter int ACC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums a run of adder-tree beats (one per K-tile)
// into one saturated unsigned dot product per output row.
module psum_accumulator #(
    parameter int IN_W  = 25,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  cfg_beats,
    psum_accumulator_if.slave bus,
    output logic              busy
);
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [ACC_W-1:0] res, res_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] beats_lat, beats_n;
    logic [CNT_W-1:0] first_beats;
    logic [CNT_W-1:0] cnt_inc;
    logic             ovf, ovf_n;
    logic             accept;
    logic [SUM_W-1:0] sat_sum;

    // Unsigned add with one guard bit; once a group has clamped it stays
    // clamped so the result never wraps back below full scale.
    // Returns {overflow_flag, clamped_sum}.
    function automatic logic [SUM_W-1:0] sat_add(
        input logic [ACC_W-1:0] a,
        input logic [IN_W-1:0]  b,
        input logic             sticky
    );
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + SUM_W'(b);
        if (sum[ACC_W] || sticky) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return {1'b0, sum[ACC_W-1:0]};
    endfunction

    assign bus.in_ready  = (state != HOLD);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = res;
    assign bus.out_ovf   = ovf;
    assign busy          = (state != IDLE);

    assign accept      = bus.in_valid && bus.in_ready;
    assign first_beats = (cfg_beats == '0) ? CNT_W'(1) : cfg_beats;
    assign cnt_inc     = cnt + CNT_W'(1);
    assign sat_sum     = sat_add(acc, bus.in_data, ovf);

    // Next-state and datapath update; every target defaults to holding.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        res_n   = res;
        cnt_n   = cnt;
        beats_n = beats_lat;
        ovf_n   = ovf;
        case (state)
            IDLE: begin
                if (accept) begin
                    acc_n   = ACC_W'(bus.in_data);
                    cnt_n   = CNT_W'(1);
                    beats_n = first_beats;
                    ovf_n   = 1'b0;
                    if (first_beats == CNT_W'(1)) begin
                        res_n   = ACC_W'(bus.in_data);
                        state_n = HOLD;
                    end else begin
                        state_n = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_n = sat_sum[ACC_W-1:0];
                    ovf_n = sat_sum[ACC_W];
                    cnt_n = cnt_inc;
                    if (cnt_inc == beats_lat) begin
                        res_n   = sat_sum[ACC_W-1:0];
                        state_n = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and accumulator registers; reset discards any partial or held group.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            res       <= '0;
            cnt       <= '0;
            beats_lat <= '0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            res       <= res_n;
            cnt       <= cnt_n;
            beats_lat <= beats_n;
            ovf       <= ovf_n;
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: a 32-bit instance for the general
// cases and a 25-bit instance for saturation.
module tb_psum_accumulator;
    typedef struct packed {
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cfg_a, cfg_b;
    logic       busy_a, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    longint unsigned bq[$];

    psum_accumulator_if #(.IN_W(25), .ACC_W(32)) ia ();
    psum_accumulator_if #(.IN_W(25), .ACC_W(25)) ib ();

    psum_accumulator #(.IN_W(25), .ACC_W(32), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_a), .bus(ia), .busy(busy_a)
    );

    psum_accumulator #(.IN_W(25), .ACC_W(25), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_b), .bus(ib), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t model(input longint unsigned beats[$], input int w);
        longint unsigned s;
        longint unsigned mx;
        exp_t r;
        mx    = (64'd1 << w) - 64'd1;
        s     = 0;
        r.ovf = 1'b0;
        foreach (beats[i]) begin
            s += beats[i];
            if (s > mx) r.ovf = 1'b1;
        end
        r.data = r.ovf ? mx[31:0] : s[31:0];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Result monitors: a handshake seen at the falling edge completes at the next rising edge.
    always begin
        exp_t e;
        @(negedge clk);
        if (rst_n && ia.out_valid && ia.out_ready) begin
            chk("a_sb_nonempty", 64'(sb_a.size() > 0), 64'd1);
            if (sb_a.size() > 0) begin
                e = sb_a.pop_front();
                chk("a_out_data", 64'(ia.out_data), 64'(e.data));
                chk("a_out_ovf", 64'(ia.out_ovf), 64'(e.ovf));
            end
        end
    end

    always begin
        exp_t e;
        @(negedge clk);
        if (rst_n && ib.out_valid && ib.out_ready) begin
            chk("b_sb_nonempty", 64'(sb_b.size() > 0), 64'd1);
            if (sb_b.size() > 0) begin
                e = sb_b.pop_front();
                chk("b_out_data", 64'(ib.out_data), 64'(e.data));
                chk("b_out_ovf", 64'(ib.out_ovf), 64'(e.ovf));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        cfg_a        = 8'd0;
        cfg_b        = 8'd0;
        ia.in_valid  = 1'b0;
        ia.in_data   = '0;
        ia.out_ready = 1'b1;
        ib.in_valid  = 1'b0;
        ib.in_data   = '0;
        ib.out_ready = 1'b1;
        step();
        step();

        // Reset state
        chk("rst_in_ready", 64'(ia.in_ready), 64'd1);
        chk("rst_out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst_out_data", 64'(ia.out_data), 64'd0);
        chk("rst_out_ovf", 64'(ia.out_ovf), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic three-beat group
        bq = {100, 200, 300};
        sb_a.push_back(model(bq, 32));
        cfg_a = 8'd3;
        ia.in_valid = 1'b1;
        ia.in_data  = 25'd100;
        step();
        chk("t1_busy", 64'(busy_a), 64'd1);
        ia.in_data = 25'd200;
        step();
        chk("t1_no_early_valid", 64'(ia.out_valid), 64'd0);
        ia.in_data = 25'd300;
        step();
        ia.in_valid = 1'b0;
        chk("t1_latency", 64'(ia.out_valid), 64'd1);
        chk("t1_hold_in_ready", 64'(ia.in_ready), 64'd0);
        step();
        chk("t1_one_cycle", 64'(ia.out_valid), 64'd0);
        chk("t1_data_kept", 64'(ia.out_data), 64'd600);

        // Single beat with cfg_beats=0
        bq = {20971510};
        sb_a.push_back(model(bq, 32));
        cfg_a = 8'd0;
        ia.in_valid = 1'b1;
        ia.in_data  = 25'd20971510;
        step();
        ia.in_valid = 1'b0;
        chk("t2_latency", 64'(ia.out_valid), 64'd1);
        step();
        chk("t2_idle", 64'(busy_a), 64'd0);

        // Backpressure in HOLD
        bq = {5};
        sb_a.push_back(model(bq, 32));
        cfg_a = 8'd1;
        ia.out_ready = 1'b0;
        ia.in_valid  = 1'b1;
        ia.in_data   = 25'd5;
        step();
        ia.in_data = 25'd7;
        chk("t3_hold_valid", 64'(ia.out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_in_ready_low", 64'(ia.in_ready), 64'd0);
            chk("t3_data_stable", 64'(ia.out_data), 64'd5);
            step();
        end
        bq = {7};
        sb_a.push_back(model(bq, 32));
        ia.out_ready = 1'b1;
        step();
        chk("t3_idle_ready", 64'(ia.in_ready), 64'd1);
        chk("t3_idle_no_valid", 64'(ia.out_valid), 64'd0);
        step();
        ia.in_valid = 1'b0;
        chk("t3_next_accepted", 64'(ia.out_valid), 64'd1);
        step();

        // Reset mid-group
        cfg_a = 8'd4;
        ia.in_valid = 1'b1;
        ia.in_data  = 25'd50;
        step();
        step();
        ia.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("t5_out_valid", 64'(ia.out_valid), 64'd0);
        chk("t5_busy", 64'(busy_a), 64'd0);
        chk("t5_in_ready", 64'(ia.in_ready), 64'd1);
        chk("t5_out_data", 64'(ia.out_data), 64'd0);
        rst_n = 1'b1;
        bq = {10, 10, 10, 10};
        sb_a.push_back(model(bq, 32));
        ia.in_valid = 1'b1;
        ia.in_data  = 25'd10;
        for (int i = 0; i < 4; i++) step();
        ia.in_valid = 1'b0;
        chk("t5_latency", 64'(ia.out_valid), 64'd1);
        step();

        // Bubbles with a cfg_beats change after the first beat
        bq = {1, 2, 3, 4};
        sb_a.push_back(model(bq, 32));
        cfg_a = 8'd4;
        for (int b = 1; b <= 4; b++) begin
            ia.in_valid = 1'b1;
            ia.in_data  = 25'(b);
            step();
            cfg_a = 8'd2;
            ia.in_valid = 1'b0;
            if (b == 4) begin
                chk("t6_closed", 64'(ia.out_valid), 64'd1);
            end else begin
                chk("t6_still_open", 64'(ia.out_valid), 64'd0);
                step();
                chk("t6_bubble_busy", 64'(busy_a), 64'd1);
                step();
            end
        end
        step();

        // Saturation on the 25-bit instance, then a clean group
        bq = {33554431, 1, 5};
        sb_b.push_back(model(bq, 25));
        cfg_b = 8'd3;
        ib.in_valid = 1'b1;
        ib.in_data  = 25'd33554431;
        step();
        ib.in_data = 25'd1;
        step();
        ib.in_data = 25'd5;
        step();
        ib.in_valid = 1'b0;
        chk("t4_sat_valid", 64'(ib.out_valid), 64'd1);
        chk("t4_sat_flag", 64'(ib.out_ovf), 64'd1);
        step();
        bq = {4};
        sb_b.push_back(model(bq, 25));
        cfg_b = 8'd1;
        ib.in_valid = 1'b1;
        ib.in_data  = 25'd4;
        step();
        ib.in_valid = 1'b0;
        chk("t4_clean_ovf", 64'(ib.out_ovf), 64'd0);
        step();

        for (int i = 0; i < 50 && (sb_a.size() != 0 || sb_b.size() != 0); i++) step();
        chk("sb_a_drained", 64'(sb_a.size()), 64'd0);
        chk("sb_b_drained", 64'(sb_b.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream consumer of the unsigned 10-input adder tree in the GEMV datapath.
- Takes one tree sum per beat over a valid/ready handshake and accumulates a run of beats (one per K-tile) into a single output-row dot product.
- Emits the saturated unsigned total on a valid/ready output.
- Lets the combinational tree be reused across K-tiles without widening it.

Parameters:
- IN_W, 25, width of the adder-tree sum (tree operand width 21 + 4 growth bits).
- ACC_W, 32, accumulator and output width; must be >= IN_W.
- CNT_W, 8, width of the beat-count configuration and internal beat counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- cfg_beats  input  CNT_W  beats per group; sampled only on the first beat of a group.
- in_valid  input  1  tree sum on in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  IN_W  unsigned adder-tree sum.
- out_valid  output  1  group result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  unsigned accumulated result, saturated.
- out_ovf  output  1  saturation occurred in this group; valid with out_valid.
- busy  output  1  group in progress (state ACCUM or HOLD).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled at the rising edge.
- Reset values:
  - state=IDLE.
  - in_ready=1 (combinational, from state).
  - out_valid=0, out_data=0, out_ovf=0, busy=0.
  - Internal accumulator, counter and latched beat count all 0.
- Beat acceptance: a beat is accepted on a cycle where in_valid && in_ready. in_data is zero-extended to ACC_W+1 bits for the add.
- State IDLE:
  - in_ready=1.
  - On accept:
    - acc<=in_data; cnt<=1.
    - beats_lat<=(cfg_beats==0)?1:cfg_beats.
    - ovf<=0.
    - Go to HOLD if beats_lat==1, else go to ACCUM.
- State ACCUM:
  - in_ready=1.
  - On accept: sum=acc+in_data computed at ACC_W+1 bits.
    - If sum[ACC_W]=1 or the group has already saturated: acc<=all-ones and ovf<=1.
    - Otherwise acc<=sum[ACC_W-1:0].
    - cnt<=cnt+1.
    - Go to HOLD when cnt+1==beats_lat.
  - Cycles without in_valid (bubbles) hold all state.
- State HOLD:
  - in_ready=0. out_valid=1, out_data=acc, out_ovf=ovf.
  - Outputs stay stable while out_ready=0.
  - On out_ready: go to IDLE. out_valid=0 on the next cycle.
- Latency:
  - Last beat accepted at edge t → out_valid=1 in the cycle after t.
  - Minimum group period is beats+1 cycles (one bubble per group for the HOLD handshake).
- cfg_beats: changes after the first beat of a group are ignored. A value of 0 is treated as 1.
- Saturation:
  - Unsigned clamp to 2^ACC_W-1; the clamp is sticky for the rest of the group.
  - out_ovf clears when the next group starts.
  - With defaults, saturation is unreachable below 204 beats; it is tested with a reduced ACC_W.
- Reset mid-operation: rst_n=0 at any state discards the partial group and returns all outputs to their reset values on the next edge. Any result held in HOLD is lost.
- busy: 1 in ACCUM and HOLD, 0 in IDLE.
- No X propagation: out_data holds the last result (or 0 after reset) when out_valid=0.

Test Plan:
1. Basic group: cfg_beats=3; in_data=100, 200, 300 on consecutive cycles with out_ready=1 → out_valid=1 for one cycle, exactly one cycle after the 3rd accept; out_data=600; out_ovf=0.
2. Single beat: cfg_beats=0; in_data=20971510 (10×(2^21−1)) → out_data=20971510, out_valid high the cycle after accept.
3. Backpressure: hold out_ready=0 for 5 cycles in HOLD with in_valid=1 and in_data=7 → in_ready=0, out_data stable. Then out_ready=1 → next group's first beat (7) is accepted in IDLE the following cycle.
4. Saturation: ACC_W=25 instance; cfg_beats=3; in_data=2^25−1, 1, 5 → out_data=33554431, out_ovf=1. Next group with cfg_beats=1 and in_data=4 → out_data=4, out_ovf=0.
5. Reset mid-group: cfg_beats=4; accept 2 beats of 50; drive rst_n=0 for 1 cycle → out_valid=0, busy=0, in_ready=1. Then 4 beats of 10 → out_data=40.
6. Bubbles and config change: cfg_beats=4; beats 1, 2, 3, 4 with 2-cycle in_valid gaps; change cfg_beats to 2 after the first beat → group still closes after 4 beats, out_data=10.
